// File: rtl/fuzz_op_scheduler.sv
// Round-robin arbiter that shares one combinational fuzz datapath among NREQ requesters.
// Each granted bundle is held on the operand lines for SETTLE cycles, then y is captured and returned.
module fuzz_op_scheduler #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*53-1:0]         req_ops,
    output logic [10:0]                dp_w0,
    output logic [11:0]                dp_w1,
    output logic [9:0]                 dp_w2,
    output logic [8:0]                 dp_w3,
    output logic [10:0]                dp_w4,
    input  logic [81:0]                dp_y,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [81:0]                rsp_data,
    output logic                       rsp_lsb_err,
    output logic                       busy
);
    localparam int IDW = $clog2(NREQ);

    // state    | meaning
    // S_IDLE   | waiting for any req_valid, picks next requester after r_last
    // S_GRANT  | req_ready pulsed to the chosen requester for one cycle
    // S_SETTLE | operands held on dp_w*, counting down before y is captured
    // S_RESP   | response held until the consumer accepts it
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SETTLE, S_RESP} state_t;

    state_t            r_state;
    logic              r_run;
    logic [IDW-1:0]    r_last;
    logic [IDW-1:0]    r_grant;
    logic [IDW-1:0]    r_id;
    logic [NREQ-1:0]   r_req_ready;
    logic [3:0]        r_cnt;
    logic [10:0]       r_w0;
    logic [11:0]       r_w1;
    logic [9:0]        r_w2;
    logic [8:0]        r_w3;
    logic [10:0]       r_w4;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [81:0]       r_rsp_data;
    logic              r_rsp_lsb_err;
    logic              r_busy;

    logic [IDW-1:0]    w_pick;
    logic [52:0]       w_ops;

    // Walk downwards so the last hit is the nearest valid index after r_last.
    always_comb begin
        w_pick = r_last;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(r_last) + k) % NREQ]) begin
                w_pick = IDW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_ops = req_ops[int'(r_grant) * 53 +: 53];

    // r_run holds off arbitration for one clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_run         <= 1'b0;
            r_last        <= IDW'(NREQ - 1);
            r_grant       <= '0;
            r_id          <= '0;
            r_req_ready   <= '0;
            r_cnt         <= '0;
            r_w0          <= '0;
            r_w1          <= '0;
            r_w2          <= '0;
            r_w3          <= '0;
            r_w4          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_data    <= '0;
            r_rsp_lsb_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_run && (|req_valid)) begin
                        r_grant     <= w_pick;
                        r_req_ready <= NREQ'(1) << w_pick;
                        r_state     <= S_GRANT;
                        r_busy      <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_req_ready <= '0;
                    if (req_valid[r_grant]) begin
                        r_w0    <= w_ops[10:0];
                        r_w1    <= w_ops[22:11];
                        r_w2    <= w_ops[32:23];
                        r_w3    <= w_ops[41:33];
                        r_w4    <= w_ops[52:42];
                        r_id    <= r_grant;
                        r_last  <= r_grant;
                        r_cnt   <= 4'(SETTLE);
                        r_state <= S_SETTLE;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data    <= dp_y;
                        r_rsp_lsb_err <= dp_y[0];
                        r_rsp_id      <= r_id;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign dp_w0       = r_w0;
    assign dp_w1       = r_w1;
    assign dp_w2       = r_w2;
    assign dp_w3       = r_w3;
    assign dp_w4       = r_w4;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_lsb_err = r_rsp_lsb_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_fuzz_op_scheduler.sv
// Bench for fuzz_op_scheduler: random bundles and valid masks against a round-robin reference
// model, with a simple combinational datapath model driving dp_y.
module tb_fuzz_op_scheduler;
    localparam int NREQ   = 4;
    localparam int SETTLE = 1;
    localparam int IDW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*53-1:0]    req_ops;
    logic [10:0]           dp_w0;
    logic [11:0]           dp_w1;
    logic [9:0]            dp_w2;
    logic [8:0]            dp_w3;
    logic [10:0]           dp_w4;
    logic [81:0]           dp_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [81:0]           rsp_data;
    logic                  rsp_lsb_err;
    logic                  busy;
    logic                  force_lsb;

    logic [52:0]           m_ops [NREQ];
    int                    m_last;
    int                    n_chk;
    int                    n_bad;

    fuzz_op_scheduler #(.NREQ(NREQ), .SETTLE(SETTLE)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ops     (req_ops),
        .dp_w0       (dp_w0),
        .dp_w1       (dp_w1),
        .dp_w2       (dp_w2),
        .dp_w3       (dp_w3),
        .dp_w4       (dp_w4),
        .dp_y        (dp_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_lsb_err (rsp_lsb_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: bit 0 is the tie-off bit, forced to 1 only when force_lsb is set.
    function automatic logic [81:0] y_of(input logic [52:0] b, input logic f);
        return {b, b[22:11], b[32:23], b[41:36], f};
    endfunction

    assign dp_y = y_of({dp_w4, dp_w3, dp_w2, dp_w1, dp_w0}, force_lsb);

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input bit rnd);
        for (int i = 0; i < NREQ; i++) begin
            if (rnd) m_ops[i] = {21'($urandom), 32'($urandom)};
            req_ops[53*i +: 53] = m_ops[i];
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic outs_any();
        return |{req_ready, dp_w0, dp_w1, dp_w2, dp_w3, dp_w4, rsp_valid, rsp_id,
                 rsp_data, rsp_lsb_err, busy};
    endfunction

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 50 && g < 0; n++) begin
            tick();
            if (req_ready != '0) begin
                chk("onehot", 82'($countones(req_ready)), 82'(1));
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            end
        end
        if (g < 0) chk("grant_timeout", 82'(|req_ready), 82'(1));
    endtask

    task automatic finish_txn(input int g, input bit drop, input int hold);
        logic [52:0] prev;
        logic [81:0] sd;
        logic [IDW-1:0] sid;
        int n;
        prev = {dp_w4, dp_w3, dp_w2, dp_w1, dp_w0};
        if (drop) begin
            req_valid[g] = 1'b0;
            tick();
            chk("drop_busy", 82'(busy), 82'(0));
            chk("drop_dp", 82'({dp_w4, dp_w3, dp_w2, dp_w1, dp_w0}), 82'(prev));
            chk("drop_rsp", 82'(rsp_valid), 82'(0));
            return;
        end
        rsp_ready = (hold == 0);
        tick();
        chk("dp_w", 82'({dp_w4, dp_w3, dp_w2, dp_w1, dp_w0}), 82'(m_ops[g]));
        chk("rdy_low", 82'(req_ready), 82'(0));
        m_last = g;
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 82'(n), 82'(SETTLE + 2));
        chk("rsp_id", 82'(rsp_id), 82'(g));
        chk("rsp_data", rsp_data, y_of(m_ops[g], force_lsb));
        chk("lsb_err", 82'(rsp_lsb_err), 82'(force_lsb));
        sd  = rsp_data;
        sid = rsp_id;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_v", 82'(rsp_valid), 82'(1));
            chk("hold_d", rsp_data, sd);
            chk("hold_id", 82'(rsp_id), 82'(sid));
            chk("hold_rdy", 82'(req_ready), 82'(0));
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_clr", 82'(rsp_valid), 82'(0));
        chk("idle", 82'(busy), 82'(0));
    endtask

    task automatic run_txn(input logic [NREQ-1:0] mask, input bit drop, input int hold,
                           input bit rnd);
        int g;
        int exp_g;
        req_valid = mask;
        load_ops(rnd);
        exp_g = model_pick(mask);
        wait_grant(g);
        chk("grant", 82'(g), 82'(exp_g));
        if (g >= 0 && g == exp_g) finish_txn(g, drop, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        logic [NREQ-1:0] mask;
        n_chk = 0;
        n_bad = 0;
        force_lsb = 1'b0;
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        m_last = NREQ - 1;
        load_ops(1'b1);

        // reset with all requesters valid, then requester 0 wins first
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outs", 82'(outs_any()), 82'(0));
        end
        rst_n = 1'b1;
        tick();
        chk("rst_rdy_c1", 82'(req_ready), 82'(0));
        tick();
        chk("rst_rdy_c2", 82'(req_ready), 82'(4'b0001));
        finish_txn(0, 1'b0, 0);

        // all valid: strict rotation
        for (int t = 0; t < 8; t++) run_txn(4'b1111, 1'b0, 0, 1'b1);

        // single requester with fixed operand corners
        m_ops[2] = {11'h400, 9'h1F8, 10'h200, 12'h000, 11'h7FF};
        run_txn(4'b0100, 1'b0, 0, 1'b0);
        chk("t2_w0", 82'(dp_w0), 82'(11'h7FF));
        chk("t2_w2", 82'(dp_w2), 82'(10'h200));
        chk("t2_w4", 82'(dp_w4), 82'(11'h400));

        // consumer stall in RESP
        run_txn(4'b1111, 1'b0, 10, 1'b1);

        // pointer to 0, then requester 1 withdraws in its grant cycle and re-asserts
        run_txn(4'b0001, 1'b0, 0, 1'b1);
        run_txn(4'b1110, 1'b1, 0, 1'b1);
        run_txn(4'b1110, 1'b0, 0, 1'b1);

        // tie-off bit error reported
        force_lsb = 1'b1;
        run_txn(4'b1010, 1'b0, 1, 1'b1);
        force_lsb = 1'b0;

        // random masks, stalls and withdrawals
        for (int t = 0; t < 24; t++) begin
            mask = 4'($urandom_range(1, 15));
            run_txn(mask, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), 1'b1);
        end

        // reset during SETTLE drops the bundle
        req_valid = 4'b0010;
        load_ops(1'b1);
        wait_grant(g);
        chk("rs_grant", 82'(g), 82'(model_pick(4'b0010)));
        tick();
        chk("rs_busy", 82'(busy), 82'(1));
        rst_n = 1'b0;
        #1;
        chk("rs_outs", 82'(outs_any()), 82'(0));
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        m_last = NREQ - 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rs_norsp", 82'({rsp_valid, req_ready}), 82'(0));
        end
        run_txn(4'b1111, 1'b0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
